// File: rtl/lpif_txrx_x16_q2_pkg.sv
// Shared logic-link word layout for the x16 quarter-rate LPIF packer/unpacker pair.
package lpif_txrx_x16_q2_pkg;

  localparam int unsigned W_STATE  = 4;
  localparam int unsigned W_PROTID = 2;
  localparam int unsigned W_DATA   = 1024;
  localparam int unsigned W_BSTART = 7;
  localparam int unsigned W_BVALID = 128;
  localparam int unsigned W_VALID  = 1;

  localparam int unsigned OFF_STATE  = 0;
  localparam int unsigned OFF_PROTID = 4;
  localparam int unsigned OFF_DATA   = 6;
  localparam int unsigned OFF_BSTART = 1030;
  localparam int unsigned OFF_BVALID = 1037;
  localparam int unsigned OFF_VALID  = 1165;

  localparam int unsigned W_TOTAL = OFF_VALID + W_VALID;

  localparam int unsigned W_DATA_GEN1   = 512;
  localparam int unsigned W_BVALID_GEN1 = 64;

  // Field order (MSB first) matches the offsets above.
  typedef struct packed {
    logic                valid;
    logic [W_BVALID-1:0] bvalid;
    logic [W_BSTART-1:0] bstart;
    logic [W_DATA-1:0]   data;
    logic [W_PROTID-1:0] protid;
    logic [W_STATE-1:0]  state;
  } lpif_word_t;

  // Gen1 links carry only the lower half of data and byte-valid.
  function automatic logic [W_TOTAL-1:0] gen1_mask(input logic [W_TOTAL-1:0] w,
                                                   input logic               gen2);
    logic [W_TOTAL-1:0] m;
    m = w;
    if (!gen2) begin
      m[OFF_DATA + W_DATA_GEN1 +: (W_DATA - W_DATA_GEN1)]       = '0;
      m[OFF_BVALID + W_BVALID_GEN1 +: (W_BVALID - W_BVALID_GEN1)] = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/lpif_txrx_x16_q2_slave_buf_if.sv
// Downstream/upstream logic-link and LPIF field bundle for the slave-end buffer.
interface lpif_txrx_x16_q2_slave_buf_if;
  import lpif_txrx_x16_q2_pkg::*;

  logic [W_TOTAL-1:0]  rxfifo_downstream_data;
  logic                rxfifo_downstream_valid;
  logic                rxfifo_downstream_ready;

  logic [W_STATE-1:0]  dstrm_state;
  logic [W_PROTID-1:0] dstrm_protid;
  logic [W_DATA-1:0]   dstrm_data;
  logic [W_BSTART-1:0] dstrm_bstart;
  logic [W_BVALID-1:0] dstrm_bvalid;
  logic                dstrm_valid;
  logic                dstrm_ready;

  logic [W_STATE-1:0]  ustrm_state;
  logic [W_PROTID-1:0] ustrm_protid;
  logic [W_DATA-1:0]   ustrm_data;
  logic [W_BSTART-1:0] ustrm_bstart;
  logic [W_BVALID-1:0] ustrm_bvalid;
  logic                ustrm_valid;
  logic                ustrm_ready;

  logic [W_TOTAL-1:0]  txfifo_upstream_data;
  logic                txfifo_upstream_valid;
  logic                txfifo_upstream_ready;

  modport slave (
    input  rxfifo_downstream_data, rxfifo_downstream_valid,
    output rxfifo_downstream_ready,
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_bstart, dstrm_bvalid, dstrm_valid,
    input  dstrm_ready,
    input  ustrm_state, ustrm_protid, ustrm_data, ustrm_bstart, ustrm_bvalid, ustrm_valid,
    output ustrm_ready,
    output txfifo_upstream_data, txfifo_upstream_valid,
    input  txfifo_upstream_ready
  );

  modport master (
    output rxfifo_downstream_data, rxfifo_downstream_valid,
    input  rxfifo_downstream_ready,
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_bstart, dstrm_bvalid, dstrm_valid,
    output dstrm_ready,
    output ustrm_state, ustrm_protid, ustrm_data, ustrm_bstart, ustrm_bvalid, ustrm_valid,
    input  ustrm_ready,
    input  txfifo_upstream_data, txfifo_upstream_valid,
    output txfifo_upstream_ready
  );

endinterface

// File: rtl/lpif_txrx_sync_fifo.sv
// Count-based single-clock FIFO; ready reflects the registered count only.
module lpif_txrx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lpif_txrx_x16_q2_slave_buf.sv
// Slave-end x16 quarter-rate LPIF buffer: downstream unpack through an elastic FIFO,
// upstream pack through a single state-change-aware output register.
module lpif_txrx_x16_q2_slave_buf
  import lpif_txrx_x16_q2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk_wr,
  input  logic                               rst_wr_n,
  input  logic                               m_gen2_mode,
  lpif_txrx_x16_q2_slave_buf_if.slave        bus
);

  logic [W_TOTAL-1:0] head;
  logic [W_TOTAL-1:0] head_m;
  logic               head_present;
  logic               pop;
  logic [W_STATE-1:0] last_state;

  lpif_word_t         up_fields;
  logic [W_TOTAL-1:0] up_word;
  logic [W_TOTAL-1:0] tx_word;
  logic               stage_full;
  logic [W_STATE-1:0] last_sent_state;
  logic               capture;

  lpif_txrx_sync_fifo #(
    .WIDTH (W_TOTAL),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_wr),
    .rst_n     (rst_wr_n),
    .in_valid  (bus.rxfifo_downstream_valid),
    .in_ready  (bus.rxfifo_downstream_ready),
    .in_data   (bus.rxfifo_downstream_data),
    .out_valid (head_present),
    .out_ready (bus.dstrm_ready),
    .out_data  (head)
  );

  assign pop    = head_present && bus.dstrm_ready;
  assign head_m = gen1_mask(head, m_gen2_mode);

  // Empty buffer drives zeros except the sticky link state.
  assign bus.dstrm_state  = head_present ? head_m[OFF_STATE  +: W_STATE]  : last_state;
  assign bus.dstrm_protid = head_present ? head_m[OFF_PROTID +: W_PROTID] : '0;
  assign bus.dstrm_data   = head_present ? head_m[OFF_DATA   +: W_DATA]   : '0;
  assign bus.dstrm_bstart = head_present ? head_m[OFF_BSTART +: W_BSTART] : '0;
  assign bus.dstrm_bvalid = head_present ? head_m[OFF_BVALID +: W_BVALID] : '0;
  assign bus.dstrm_valid  = head_present & head_m[OFF_VALID +: W_VALID];

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n)  last_state <= '0;
    else if (pop)   last_state <= head[OFF_STATE +: W_STATE];
  end

  assign up_fields = '{
    valid:  bus.ustrm_valid,
    bvalid: bus.ustrm_bvalid,
    bstart: bus.ustrm_bstart,
    data:   bus.ustrm_data,
    protid: bus.ustrm_protid,
    state:  bus.ustrm_state
  };
  assign up_word = gen1_mask(up_fields, m_gen2_mode);

  // Idle adapter cycles are only forwarded when the link state moves.
  assign bus.ustrm_ready = !stage_full || bus.txfifo_upstream_ready;
  assign capture = (bus.ustrm_valid || (bus.ustrm_state != last_sent_state)) && bus.ustrm_ready;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      stage_full      <= 1'b0;
      tx_word         <= '0;
      last_sent_state <= '0;
    end else if (capture) begin
      stage_full      <= 1'b1;
      tx_word         <= up_word;
      last_sent_state <= bus.ustrm_state;
    end else if (bus.txfifo_upstream_ready) begin
      stage_full      <= 1'b0;
    end
  end

  assign bus.txfifo_upstream_valid = stage_full;
  assign bus.txfifo_upstream_data  = tx_word;

endmodule

// File: tb/tb_lpif_txrx_x16_q2_slave_buf.sv
// Self-checking bench for lpif_txrx_x16_q2_slave_buf: directed sequences, an upstream
// vector table and a randomized phase against a queue-based reference model.
module tb_lpif_txrx_x16_q2_slave_buf;
  import lpif_txrx_x16_q2_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk_wr;
  logic rst_wr_n;
  logic m_gen2_mode;

  lpif_txrx_x16_q2_slave_buf_if bus();

  lpif_txrx_x16_q2_slave_buf #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_wr      (clk_wr),
    .rst_wr_n    (rst_wr_n),
    .m_gen2_mode (m_gen2_mode),
    .bus         (bus)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  int checks   = 0;
  int failures = 0;

  lpif_word_t dw;
  lpif_word_t tw;
  lpif_word_t us_drive;

  assign dw = '{valid: bus.dstrm_valid, bvalid: bus.dstrm_bvalid, bstart: bus.dstrm_bstart,
                data: bus.dstrm_data, protid: bus.dstrm_protid, state: bus.dstrm_state};
  assign tw = bus.txfifo_upstream_data;

  assign bus.ustrm_valid  = us_drive.valid;
  assign bus.ustrm_bvalid = us_drive.bvalid;
  assign bus.ustrm_bstart = us_drive.bstart;
  assign bus.ustrm_data   = us_drive.data;
  assign bus.ustrm_protid = us_drive.protid;
  assign bus.ustrm_state  = us_drive.state;

  // Reference model state.
  lpif_word_t ds_q[$];
  logic [3:0] ds_last;
  lpif_word_t us_q[$];
  logic [3:0] us_last;

  typedef struct {
    bit         uv;
    logic [3:0] st;
    bit         tr;
    bit         e_rdy;
    bit         e_txv;
    logic [3:0] e_st;
    bit         e_vb;
  } up_vec_t;

  up_vec_t    tbl [10];
  lpif_word_t cw  [5];

  function automatic logic [31:0] sig(input lpif_word_t w);
    logic [37*32-1:0] t;
    logic [31:0]      s;
    t = {18'b0, w};
    s = '0;
    for (int c = 0; c < 37; c++) s ^= t[c*32 +: 32];
    return s;
  endfunction

  function automatic lpif_word_t rand_word();
    logic [37*32-1:0] t;
    for (int i = 0; i < 37; i++) t[i*32 +: 32] = $urandom;
    return t[W_TOTAL-1:0];
  endfunction

  function automatic lpif_word_t ref_mask(input lpif_word_t w, input logic gen2);
    lpif_word_t m;
    m = w;
    if (!gen2) begin
      m.data[1023:512] = '0;
      m.bvalid[127:64] = '0;
    end
    return m;
  endfunction

  function automatic lpif_word_t exp_dstrm();
    lpif_word_t e;
    e = '0;
    if (ds_q.size() == 0) e.state = ds_last;
    else                  e = ref_mask(ds_q[0], m_gen2_mode);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input lpif_word_t act, input lpif_word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual_sig=%h required_sig=%h", nm, sig(act), sig(exp));
    end
  endtask

  // One clock edge; the model advances from the inputs applied before the edge.
  task automatic cycle();
    bit         push, pop, drn, cap;
    lpif_word_t din, uin;
    logic [3:0] ust;
    din  = bus.rxfifo_downstream_data;
    uin  = ref_mask(us_drive, m_gen2_mode);
    ust  = us_drive.state;
    push = bus.rxfifo_downstream_valid && (ds_q.size() < DEPTH);
    pop  = (ds_q.size() != 0) && bus.dstrm_ready;
    drn  = (us_q.size() != 0) && bus.txfifo_upstream_ready;
    cap  = (us_drive.valid || (ust != us_last)) && ((us_q.size() == 0) || bus.txfifo_upstream_ready);
    @(posedge clk_wr);
    if (pop) begin
      ds_last = ds_q[0].state;
      void'(ds_q.pop_front());
    end
    if (push) ds_q.push_back(din);
    if (drn)  void'(us_q.pop_front());
    if (cap) begin
      us_q.push_back(uin);
      us_last = ust;
    end
    #1;
  endtask

  task automatic cmp_model();
    chk("rx_ready", 4'(bus.rxfifo_downstream_ready), (ds_q.size() < DEPTH) ? 4'd1 : 4'd0);
    chkw("dstrm", dw, exp_dstrm());
    chk("ustrm_ready", 4'(bus.ustrm_ready),
        ((us_q.size() == 0) || bus.txfifo_upstream_ready) ? 4'd1 : 4'd0);
    chk("tx_valid", 4'(bus.txfifo_upstream_valid), 4'(us_q.size()));
    if (us_q.size() != 0) chkw("tx_data", tw, us_q[0]);
  endtask

  task automatic do_reset(input logic gen2);
    rst_wr_n                    = 1'b0;
    m_gen2_mode                 = gen2;
    bus.rxfifo_downstream_valid = 1'b0;
    bus.rxfifo_downstream_data  = '0;
    bus.dstrm_ready             = 1'b0;
    bus.txfifo_upstream_ready   = 1'b0;
    us_drive                    = '0;
    ds_q.delete();
    us_q.delete();
    ds_last = '0;
    us_last = '0;
    repeat (2) @(posedge clk_wr);
    #3 rst_wr_n = 1'b1;
    #1;
  endtask

  initial begin
    lpif_word_t w, e;

    // uv st tr | rdy txv st vb  (starts idle, last sent state 0)
    tbl[0] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[1] = '{1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0};
    tbl[2] = '{1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[3] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1};
    tbl[4] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1};
    tbl[5] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1};
    tbl[6] = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[7] = '{1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0};
    tbl[8] = '{1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0};
    tbl[9] = '{1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};

    // Reset values.
    do_reset(1'b1);
    chk("rst_rx_ready", 4'(bus.rxfifo_downstream_ready), 4'd1);
    chkw("rst_dstrm", dw, '0);
    chk("rst_ustrm_ready", 4'(bus.ustrm_ready), 4'd1);
    chk("rst_tx_valid", 4'(bus.txfifo_upstream_valid), 4'd0);
    chkw("rst_tx_data", tw, '0);

    // Single word through the downstream buffer; state sticks after pop.
    w = '0; w.state = 4'h1; w.protid = 2'h2; w.data = '1; w.valid = 1'b1;
    bus.rxfifo_downstream_data  = w;
    bus.rxfifo_downstream_valid = 1'b1;
    cycle();
    bus.rxfifo_downstream_valid = 1'b0;
    #1 chkw("b_head", dw, w);
    bus.dstrm_ready = 1'b1;
    cycle();
    bus.dstrm_ready = 1'b0;
    e = '0; e.state = 4'h1;
    #1 chkw("b_after_pop", dw, e);

    // Fill to full, reject the fifth, refill after one pop, drain in order.
    for (int i = 0; i < 5; i++) begin
      cw[i] = rand_word();
      cw[i].valid = 1'b1;
      cw[i].state = 4'(i + 2);
    end
    for (int i = 0; i < 4; i++) begin
      bus.rxfifo_downstream_data  = cw[i];
      bus.rxfifo_downstream_valid = 1'b1;
      #1 chk("c_ready_fill", 4'(bus.rxfifo_downstream_ready), 4'd1);
      cycle();
    end
    bus.rxfifo_downstream_data = cw[4];
    #1 chk("c_ready_full", 4'(bus.rxfifo_downstream_ready), 4'd0);
    cycle();
    chk("c_fifth_rejected", 4'(bus.rxfifo_downstream_ready), 4'd0);
    chkw("c_head0", dw, cw[0]);
    bus.dstrm_ready = 1'b1;
    #1 chk("c_no_bypass", 4'(bus.rxfifo_downstream_ready), 4'd0);
    cycle();
    bus.dstrm_ready = 1'b0;
    #1 chk("c_ready_after_pop", 4'(bus.rxfifo_downstream_ready), 4'd1);
    cycle();
    chk("c_fifth_accepted", 4'(bus.rxfifo_downstream_ready), 4'd0);
    bus.rxfifo_downstream_valid = 1'b0;
    bus.dstrm_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1 chkw("c_order", dw, cw[k]);
      cycle();
    end
    bus.dstrm_ready = 1'b0;
    #1 chk("c_empty_valid", 4'(bus.dstrm_valid), 4'd0);
    chk("c_empty_state", bus.dstrm_state, cw[4].state);

    // Gen1 masking on both directions.
    do_reset(1'b0);
    bus.rxfifo_downstream_data  = '1;
    bus.rxfifo_downstream_valid = 1'b1;
    us_drive = '1;
    bus.txfifo_upstream_ready = 1'b1;
    cycle();
    bus.rxfifo_downstream_valid = 1'b0;
    us_drive.valid = 1'b0;
    e = '1; e.data[1023:512] = '0; e.bvalid[127:64] = '0;
    #1 chkw("d_dstrm_gen1", dw, e);
    chk("d_tx_valid", 4'(bus.txfifo_upstream_valid), 4'd1);
    chkw("d_tx_gen1", tw, e);
    cycle();
    chk("d_no_repeat", 4'(bus.txfifo_upstream_valid), 4'd0);

    // Idle adapter with unchanged state produces nothing, then the upstream table.
    do_reset(1'b1);
    bus.txfifo_upstream_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("e_idle", 4'(bus.txfifo_upstream_valid), 4'd0);
    end
    for (int i = 0; i < 10; i++) begin
      us_drive       = rand_word();
      us_drive.valid = tbl[i].uv;
      us_drive.state = tbl[i].st;
      bus.txfifo_upstream_ready = tbl[i].tr;
      #1 chk("tbl_ustrm_ready", 4'(bus.ustrm_ready), 4'(tbl[i].e_rdy));
      cycle();
      chk("tbl_tx_valid", 4'(bus.txfifo_upstream_valid), 4'(tbl[i].e_txv));
      if (tbl[i].e_txv) begin
        chk("tbl_tx_state", tw.state, tbl[i].e_st);
        chk("tbl_tx_vbit", 4'(tw.valid), 4'(tbl[i].e_vb));
      end
    end

    // Asynchronous reset with words buffered and the upstream stage full.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.rxfifo_downstream_data  = rand_word();
      bus.rxfifo_downstream_valid = 1'b1;
      cycle();
    end
    bus.rxfifo_downstream_valid = 1'b0;
    us_drive = rand_word();
    us_drive.valid = 1'b1;
    cycle();
    us_drive.valid = 1'b0;
    #1 chk("f_stage_full", 4'(bus.txfifo_upstream_valid), 4'd1);
    chk("f_buffer_full_3", 4'(bus.rxfifo_downstream_ready), 4'd1);
    #2 rst_wr_n = 1'b0;
    #1;
    chk("f_rst_rx_ready", 4'(bus.rxfifo_downstream_ready), 4'd1);
    chkw("f_rst_dstrm", dw, '0);
    chk("f_rst_ustrm_ready", 4'(bus.ustrm_ready), 4'd1);
    chk("f_rst_tx_valid", 4'(bus.txfifo_upstream_valid), 4'd0);
    chkw("f_rst_tx_data", tw, '0);
    do_reset(1'b1);
    chk("f_post_rx_ready", 4'(bus.rxfifo_downstream_ready), 4'd1);
    chk("f_post_dstrm_valid", 4'(bus.dstrm_valid), 4'd0);

    // Randomized traffic in both link generations against the model.
    for (int g = 1; g >= 0; g--) begin
      do_reset(1'(g));
      for (int n = 0; n < 800; n++) begin
        bus.rxfifo_downstream_data  = rand_word();
        bus.rxfifo_downstream_valid = ($urandom_range(9, 0) < 6);
        bus.dstrm_ready             = ($urandom_range(1, 0) == 1);
        bus.txfifo_upstream_ready   = ($urandom_range(9, 0) < 6);
        w = rand_word();
        w.valid = ($urandom_range(9, 0) < 4);
        w.state = ($urandom_range(4, 0) == 0) ? 4'($urandom) : us_drive.state;
        us_drive = w;
        #1 cmp_model();
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpif_txrx_x16_q2_slave_buf.md
# lpif_txrx_x16_q2_slave_buf

Slave-end counterpart of the x16 quarter-rate LPIF logic-link packer. Unpacks the 1166-bit downstream logic-link word into LPIF `dstrm_*` fields through a small elastic buffer, and packs `ustrm_*` fields into the upstream logic-link word through a registered, state-change-aware output stage. Sits between the slave-side logic-link FIFOs and the slave LPIF adapter.

## Interface
- `FIFO_DEPTH`, 4: downstream buffer entries; power of two, ≥2.
- `clk_wr`  in  1  sole clock.
- `rst_wr_n`  in  1  asynchronous active-low reset.
- `rxfifo_downstream_data`  in  1166  packed word: state[0+:4], protid[4+:2], data[6+:1024], bstart[1030+:7], bvalid[1037+:128], valid[1165].
- `rxfifo_downstream_valid`  in  1  word present.
- `rxfifo_downstream_ready`  out  1  buffer not full.
- `dstrm_state` / `dstrm_protid` / `dstrm_data` / `dstrm_bstart` / `dstrm_bvalid` / `dstrm_valid`  out  4/2/1024/7/128/1  unpacked head entry.
- `dstrm_ready`  in  1  adapter consumes head this cycle.
- `ustrm_state` / `ustrm_protid` / `ustrm_data` / `ustrm_bstart` / `ustrm_bvalid` / `ustrm_valid`  in  4/2/1024/7/128/1  adapter upstream fields.
- `ustrm_ready`  out  1  upstream stage accepts.
- `txfifo_upstream_data`  out  1166  packed word, same field layout.
- `txfifo_upstream_valid`  out  1  word present.
- `txfifo_upstream_ready`  in  1  logic link accepts.
- `m_gen2_mode`  in  1  static; 0 = Gen1, only lower half of data/bvalid live.

## Operation
- Downstream write: push when `rxfifo_downstream_valid && rxfifo_downstream_ready`. Ready = count < FIFO_DEPTH (registered count, no same-cycle pop bypass).
- Downstream read: pop when count>0 && `dstrm_ready`. Outputs combinationally decode head entry.
- Empty buffer: `dstrm_valid`=0, data/bstart/bvalid/protid=0; `dstrm_state` holds state field of last popped entry (sticky link state), 4'h0 after reset.
- Gen1 (`m_gen2_mode`=0): `dstrm_data[1023:512]` and `dstrm_bvalid[127:64]` forced 0; same masking applied to `txfifo_upstream_data` data/bvalid upper halves. Gen2: full width.
- Simultaneous push/pop: count unchanged; pointers both advance, wrap modulo FIFO_DEPTH.
- Upstream capture condition: `ustrm_valid || (ustrm_state != last_sent_state)`. Otherwise adapter input ignored; `ustrm_ready` still reports stage availability.
- Upstream stage: single register. `ustrm_ready` = !stage_full || `txfifo_upstream_ready`. Capture when condition && `ustrm_ready`; stage_full set, last_sent_state updated to `ustrm_state`.
- Drain: stage_full clears when `txfifo_upstream_valid && txfifo_upstream_ready` with no new capture; capture same cycle keeps stage_full, loads new word.
- `txfifo_upstream_valid` = stage_full.

## Timing
- Reset values: FIFO count/pointers 0, `rxfifo_downstream_ready`=1, all `dstrm_*`=0, stage_full=0, `txfifo_upstream_valid`=0, `txfifo_upstream_data`=0, `ustrm_ready`=1, last_sent_state=4'h0.
- Downstream latency: word pushed at edge N visible on `dstrm_*` after edge N (first cycle N+1) when buffer was empty.
- Full: ready low cycle after count reaches FIFO_DEPTH; rises cycle after pop.
- Upstream latency: capture at edge N → `txfifo_upstream_valid` high in cycle N+1; back-to-back at full throughput while `txfifo_upstream_ready`=1.
- Reset mid-operation: immediate async clear; buffered words discarded, no partial output.

## Structure
- Shared package `lpif_txrx_x16_q2_pkg`: field offsets/widths (state 0/4, protid 4/2, data 6/1024, bstart 1030/7, bvalid 1037/128, valid 1165/1), total width 1166, Gen1 half-widths 512/64.
- One sub-module: `lpif_txrx_sync_fifo` (parameterised width/depth, count-based full/empty); upstream stage and unpack/mask logic inline.

## Test plan
- Reset then push one word state=4'h1, protid=2'h2, data=all-ones, valid=1, Gen2 → next cycle `dstrm_*` match exactly; pop with `dstrm_ready` → `dstrm_valid`=0, `dstrm_state` stays 4'h1.
- Push 5 words, `dstrm_ready`=0, FIFO_DEPTH=4 → ready low after 4th; 5th not accepted; pop one → ready high next cycle, 5th accepted; order preserved.
- Gen1 mode, push data=all-ones, bvalid=all-ones → `dstrm_data`=512'h0 upper / all-ones lower, `dstrm_bvalid[127:64]`=0; same masking on upstream.
- Upstream: `ustrm_valid`=0, state constant 4'h0 for 10 cycles → no `txfifo_upstream_valid`; state→4'h3 with valid=0 → exactly one word, state field 4'h3, valid bit 0.
- Upstream backpressure: `txfifo_upstream_ready`=0, two valid words offered → first held, `ustrm_ready`=0; ready=1 → first drains and second captured same cycle.
- Assert `rst_wr_n` low with 3 words buffered and stage full → all outputs at reset values same cycle; after release buffer empty, `rxfifo_downstream_ready`=1.
